// File: rtl/serial_alu_sequencer_pkg.sv
// Shared encodings for the bit-serial ALU: operation codes, FSM states and the
// carry-in each operation starts with.
package serial_alu_sequencer_pkg;

   localparam logic [1:0] OP_INC = 2'b00;
   localparam logic [1:0] OP_ADD = 2'b01;
   localparam logic [1:0] OP_SUB = 2'b10;
   localparam logic [1:0] OP_DEC = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

   // INC adds the +1 through the carry; SUB forms a + ~b + 1.
   function automatic logic init_carry(input logic [1:0] op);
      return (op == OP_INC) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/serial_alu_sequencer_alu_bit_slice.sv
// One controlled full-adder slice; (s1,s0) picks the b-side addend:
// 00 -> 0, 01 -> b, 10 -> ~b, 11 -> 1.
module alu_bit_slice (
   input  logic a,
   input  logic b,
   input  logic cin,
   input  logic s1,
   input  logic s0,
   output logic sum,
   output logic cout
);

   logic b_sel;

   assign b_sel = (~s1 & s0 & b) | (s1 & ~s0 & ~b) | (s1 & s0);
   assign sum   = a ^ b_sel ^ cin;
   assign cout  = (a & b_sel) | (cin & (a ^ b_sel));

endmodule

// File: rtl/serial_alu_sequencer.sv
// Bit-serial INC/ADD/SUB/DEC engine: one slice iterated WIDTH times, LSB first,
// with a start/busy/done handshake and a result that holds between operations.
module serial_alu_sequencer
   import serial_alu_sequencer_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             zero
);

   localparam int CW = $clog2(WIDTH);

   // Handshake: start is accepted only in IDLE (the edge that samples it is E0);
   // busy is high for the WIDTH cycles that follow, then done pulses for one
   // cycle as result/cout/zero update. start outside IDLE is dropped.
   state_e state, state_nxt;

   logic [WIDTH-1:0] a_sr, b_sr, r_sr;
   logic [1:0]       sel;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             last_bit;
   logic             s_sum, s_cout;

   assign last_bit = (cnt == CW'(WIDTH - 1));

   alu_bit_slice u_slice (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (carry),
      .s1   (sel[1]),
      .s0   (sel[0]),
      .sum  (s_sum),
      .cout (s_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last_bit) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         r_sr   <= '0;
         sel    <= '0;
         cnt    <= '0;
         carry  <= 1'b0;
         result <= '0;
         cout   <= 1'b0;
         zero   <= 1'b0;
      end else if (state == IDLE) begin
         if (start) begin
            a_sr  <= opa;
            b_sr  <= opb;
            sel   <= op;
            cnt   <= '0;
            carry <= init_carry(op);
         end
      end else if (state == RUN) begin
         carry <= s_cout;
         r_sr  <= {s_sum, r_sr[WIDTH-1:1]};
         a_sr  <= a_sr >> 1;
         b_sr  <= b_sr >> 1;
         // Wrap to 0 on the last bit so cnt never reaches WIDTH.
         cnt   <= last_bit ? '0 : cnt + 1'b1;
         if (last_bit) begin
            result <= {s_sum, r_sr[WIDTH-1:1]};
            cout   <= s_cout;
            zero   <= ({s_sum, r_sr[WIDTH-1:1]} == '0);
         end
      end
   end

endmodule
